// File: rtl/cmd_alu_pro_if.sv
// cmd_alu_pro_if: byte-stream bus between a host/receiver, the command
// processor and the serial transmitter.
//   din_pro/en_din_pro    : incoming command/operand byte + 1-cycle strobe
//   dout_pro/en_dout_pro  : outgoing result/status byte + 1-cycle strobe
//   rdy                   : transmitter status, 0 = ready for a byte
//   busy_pro              : processor is mid-frame or transmitting
//   err_pro               : 1-cycle pulse when a frame is aborted by timeout
// master = environment side, slave = processor side.
interface cmd_alu_pro_if;
  logic [7:0] din_pro;
  logic       en_din_pro;
  logic [7:0] dout_pro;
  logic       en_dout_pro;
  logic       rdy;
  logic       busy_pro;
  logic       err_pro;

  modport master (
    output din_pro, en_din_pro, rdy,
    input  dout_pro, en_dout_pro, busy_pro, err_pro
  );

  modport slave (
    input  din_pro, en_din_pro, rdy,
    output dout_pro, en_dout_pro, busy_pro, err_pro
  );
endinterface

// File: rtl/cmd_alu_pro.sv
// cmd_alu_pro: byte-stream ALU command processor.
// Accepts a frame {opcode, A[NB bytes], B[NB bytes]} (MSB first), executes one
// of eight operations and sends NB result bytes (MSB first) plus a status byte
// {5'b0, bad_opcode, zero, carry} to the transmitter, one byte per rdy==0.
// Ports:
//   clk  : system clock, rising edge
//   res  : asynchronous active-low reset
//   bus  : cmd_alu_pro_if.slave (din/en_din in, dout/en_dout out, rdy in,
//          busy/err out)
module cmd_alu_pro #(
  parameter int         NB      = 1,
  parameter int         TIMEOUT = 1000,
  parameter logic [7:0] OP_ADD  = 8'h0a,
  parameter logic [7:0] OP_SUB  = 8'h0b,
  parameter logic [7:0] OP_AND  = 8'h0c,
  parameter logic [7:0] OP_OR   = 8'h0d,
  parameter logic [7:0] OP_XOR  = 8'h0e,
  parameter logic [7:0] OP_CMP  = 8'h0f,
  parameter logic [7:0] OP_SHL  = 8'h10,
  parameter logic [7:0] OP_SHR  = 8'h11
) (
  input logic          clk,
  input logic          res,
  cmd_alu_pro_if.slave bus
);
  localparam int DW  = 8 * NB;
  localparam int TXW = 8 * (NB + 1);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, TX_WAIT, TX_GAP} state_t;

  state_t           state_reg;
  logic [7:0]       opcode_reg;
  logic [DW-1:0]    a_reg;
  logic [DW-1:0]    b_reg;
  logic [2:0]       byte_cnt_reg;
  logic [31:0]      tmo_cnt_reg;
  logic [TXW-1:0]   tx_buf_reg;
  logic [2:0]       tx_cnt_reg;
  logic [7:0]       dout_reg;
  logic             en_dout_reg;
  logic             busy_reg;
  logic             err_reg;

  // ALU datapath, consumed only in EXEC
  logic [DW:0]      sum_w;
  logic [DW:0]      diff_w;
  logic [DW-1:0]    result_w;
  logic             carry_w;
  logic             zero_w;
  logic             bad_w;
  logic             shift_oor_w;

  always_comb begin
    sum_w       = {1'b0, a_reg} + {1'b0, b_reg};
    // The extra top bit of the widened difference is the unsigned borrow
    diff_w      = {1'b0, a_reg} - {1'b0, b_reg};
    shift_oor_w = (b_reg >= DW'(DW));
    result_w    = '0;
    carry_w     = 1'b0;
    bad_w       = 1'b0;
    case (opcode_reg)
      OP_ADD: begin result_w = sum_w[DW-1:0];  carry_w = sum_w[DW];  end
      OP_SUB: begin result_w = diff_w[DW-1:0]; carry_w = diff_w[DW]; end
      OP_AND: result_w = a_reg & b_reg;
      OP_OR:  result_w = a_reg | b_reg;
      OP_XOR: result_w = a_reg ^ b_reg;
      OP_CMP: carry_w = diff_w[DW];
      OP_SHL: result_w = shift_oor_w ? '0 : (a_reg << b_reg);
      OP_SHR: result_w = shift_oor_w ? '0 : (a_reg >> b_reg);
      default: bad_w = 1'b1;
    endcase
    // CMP reports equality even though its result bytes are sent as zero;
    // a bad opcode never reports zero.
    if (bad_w)
      zero_w = 1'b0;
    else if (opcode_reg == OP_CMP)
      zero_w = (diff_w[DW-1:0] == '0);
    else
      zero_w = (result_w == '0);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg    <= IDLE;
      opcode_reg   <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      byte_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      tx_buf_reg   <= '0;
      tx_cnt_reg   <= '0;
      dout_reg     <= '0;
      en_dout_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      en_dout_reg <= 1'b0;
      err_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.en_din_pro) begin
            opcode_reg   <= bus.din_pro;
            byte_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= GET_A;
          end
        end
        GET_A, GET_B: begin
          // An accepted byte takes priority over an expiring timeout
          if (bus.en_din_pro) begin
            tmo_cnt_reg <= '0;
            if (state_reg == GET_A)
              a_reg <= (a_reg << 8) | DW'(bus.din_pro);
            else
              b_reg <= (b_reg << 8) | DW'(bus.din_pro);
            if (byte_cnt_reg == 3'(NB - 1)) begin
              byte_cnt_reg <= '0;
              state_reg    <= (state_reg == GET_A) ? GET_B : EXEC;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
            end
          end else if (TIMEOUT != 0 && tmo_cnt_reg == 32'(TIMEOUT - 1)) begin
            tmo_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b1;
            state_reg   <= IDLE;
          end else if (TIMEOUT != 0) begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
        EXEC: begin
          tx_buf_reg <= {result_w, 5'b0, bad_w, zero_w, carry_w};
          tx_cnt_reg <= '0;
          state_reg  <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!bus.rdy) begin
            dout_reg    <= tx_buf_reg[TXW-1 -: 8];
            en_dout_reg <= 1'b1;
            tx_buf_reg  <= tx_buf_reg << 8;
            tx_cnt_reg  <= tx_cnt_reg + 3'd1;
            state_reg   <= TX_GAP;
          end
        end
        TX_GAP: begin
          // rdy is not trusted here; the transmitter needs a cycle to raise it
          if (tx_cnt_reg == 3'(NB + 1)) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            state_reg <= TX_WAIT;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout_pro    = dout_reg;
  assign bus.en_dout_pro = en_dout_reg;
  assign bus.busy_pro    = busy_reg;
  assign bus.err_pro     = err_reg;
endmodule

// File: tb/tb_cmd_alu_pro.sv
// tb_cmd_alu_pro: drives two processors (NB=1 with TIMEOUT=20, NB=2 with the
// timeout disabled) with directed and random frames and checks every output
// byte against an arithmetic reference model.
module tb_cmd_alu_pro;
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  cmd_alu_pro_if if1 ();
  cmd_alu_pro_if if2 ();

  cmd_alu_pro #(.NB(1), .TIMEOUT(20)) u_dut1 (.clk(clk), .res(res), .bus(if1.slave));
  cmd_alu_pro #(.NB(2), .TIMEOUT(0))  u_dut2 (.clk(clk), .res(res), .bus(if2.slave));

  int vectors = 0;
  int miscompares = 0;
  byte unsigned q1[$];
  byte unsigned q2[$];
  byte unsigned exp_q[$];
  int  hold1 = 0, hold2 = 0;
  int  gap1 = 0, gap2 = 0;
  int  err1 = 0, err2 = 0;
  longint cyc = 0, last1 = -10, last2 = -10;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transmitter model: captures bytes, then stays busy (rdy=1) 0..3 cycles.
  always @(negedge clk) begin
    if (if1.en_dout_pro) begin
      check_val("spacing1", (cyc - last1 >= 2) ? 32'd1 : 32'd0, 32'd1);
      last1 = cyc;
      q1.push_back(if1.dout_pro);
      gap1 = $urandom_range(0, 3);
    end
    if (if2.en_dout_pro) begin
      check_val("spacing2", (cyc - last2 >= 2) ? 32'd1 : 32'd0, 32'd1);
      last2 = cyc;
      q2.push_back(if2.dout_pro);
      gap2 = $urandom_range(0, 3);
    end
    if (if1.err_pro) err1++;
    if (if2.err_pro) err2++;
    if (hold1 != 0) if1.rdy = 1'b1;
    else if (gap1 > 0) begin if1.rdy = 1'b1; gap1--; end
    else if1.rdy = 1'b0;
    if (hold2 != 0) if2.rdy = 1'b1;
    else if (gap2 > 0) begin if2.rdy = 1'b1; gap2--; end
    else if2.rdy = 1'b0;
  end

  // Reference model: result and flags from the opcode rules, plain arithmetic.
  function automatic void model(input logic [7:0] op, input longint unsigned a,
                                input longint unsigned b, input int nb);
    int dw = 8 * nb;
    longint unsigned mask = (64'd1 << dw) - 1;
    longint unsigned r = 0;
    bit c = 0, z = 0, bad = 0;
    case (op)
      8'h0a: begin r = (a + b) & mask; c = (((a + b) >> dw) & 1) != 0; end
      8'h0b: begin r = (a - b) & mask; c = (a < b); end
      8'h0c: r = a & b;
      8'h0d: r = a | b;
      8'h0e: r = a ^ b;
      8'h0f: begin r = 0; c = (a < b); z = (a == b); end
      8'h10: r = (b >= dw) ? 0 : ((a << b) & mask);
      8'h11: r = (b >= dw) ? 0 : (a >> b);
      default: bad = 1;
    endcase
    if (!bad && op != 8'h0f) z = (r == 0);
    exp_q.delete();
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(byte'((r >> (8 * i)) & 8'hff));
    exp_q.push_back({5'b0, bad, z, c});
  endfunction

  function automatic int qsize(input int d);
    return (d == 1) ? q1.size() : q2.size();
  endfunction

  // All drive tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int d, input logic en, input logic [7:0] b);
    if (d == 1) begin if1.en_din_pro = en; if1.din_pro = b; end
    else begin if2.en_din_pro = en; if2.din_pro = b; end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    set_din(d, 1'b1, b);
    idle(1);
    set_din(d, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int d, input logic [7:0] op,
                            input longint unsigned a, input longint unsigned b, input bit gaps);
    int nb = (d == 1) ? 1 : 2;
    send(d, op);
    for (int i = nb - 1; i >= 0; i--) begin
      if (gaps) idle($urandom_range(0, 3));
      send(d, 8'((a >> (8 * i)) & 8'hff));
    end
    for (int i = nb - 1; i >= 0; i--) begin
      if (gaps) idle($urandom_range(0, 3));
      send(d, 8'((b >> (8 * i)) & 8'hff));
    end
  endtask

  // Wait for n captured bytes; optionally throw junk strobes at the busy DUT.
  task automatic wait_bytes(input int d, input int n, input bit junk);
    int budget = 3000;
    while (qsize(d) < n && budget > 0) begin
      set_din(d, 1'b0, 8'h00);
      if (junk && ($urandom_range(0, 2) == 0)) set_din(d, 1'b1, 8'($urandom));
      idle(1);
      budget--;
    end
    set_din(d, 1'b0, 8'h00);
    if (budget == 0) check_val("wait_budget", 32'(qsize(d)), 32'(n));
  endtask

  task automatic compare_bytes(input int d, input logic [7:0] op);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = 8'hxx;
      if (d == 1 && i < q1.size()) got = q1[i];
      if (d == 2 && i < q2.size()) got = q2[i];
      check_val($sformatf("dut%0d op%02h byte%0d", d, op, i), {24'd0, got}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic run_frame(input int d, input logic [7:0] op,
                           input longint unsigned a, input longint unsigned b, input bit junk);
    model(op, a, b, (d == 1) ? 1 : 2);
    if (d == 1) q1.delete(); else q2.delete();
    send_frame(d, op, a, b, 1'b1);
    wait_bytes(d, exp_q.size(), junk);
    compare_bytes(d, op);
    idle(1);
    check_val($sformatf("dut%0d busy_after", d),
              {31'd0, (d == 1) ? if1.busy_pro : if2.busy_pro}, 32'd0);
  endtask

  initial begin
    set_din(1, 1'b0, 8'h00);
    set_din(2, 1'b0, 8'h00);
    res = 1'b0;
    idle(3);
    check_val("rst_dout1", {24'd0, if1.dout_pro}, 32'd0);
    check_val("rst_en1",   {31'd0, if1.en_dout_pro}, 32'd0);
    check_val("rst_busy1", {31'd0, if1.busy_pro}, 32'd0);
    check_val("rst_err1",  {31'd0, if1.err_pro}, 32'd0);
    check_val("rst_dout2", {24'd0, if2.dout_pro}, 32'd0);
    check_val("rst_busy2", {31'd0, if2.busy_pro}, 32'd0);
    res = 1'b1;
    idle(2);

    // Directed frames
    run_frame(1, 8'h0a, 64'h05, 64'h03, 1'b0);
    run_frame(1, 8'h0b, 64'h03, 64'h05, 1'b0);
    run_frame(1, 8'h0f, 64'h7a, 64'h7a, 1'b0);
    run_frame(1, 8'h10, 64'h81, 64'h01, 1'b0);
    run_frame(2, 8'h0a, 64'h1234, 64'h00ff, 1'b0);
    run_frame(2, 8'h0a, 64'hffff, 64'h0001, 1'b0);
    run_frame(1, 8'h55, 64'h11, 64'h22, 1'b1);
    run_frame(1, 8'h0e, 64'h3c, 64'h0f, 1'b0);
    run_frame(2, 8'h11, 64'h8000, 64'h000f, 1'b1);
    run_frame(2, 8'h10, 64'h1234, 64'h0010, 1'b0);

    // Timeout abort after 20 idle clocks, then a clean frame
    err1 = 0;
    q1.delete();
    send(1, 8'h0a);
    send(1, 8'h05);
    idle(30);
    check_val("tmo_err_pulses", 32'(err1), 32'd1);
    check_val("tmo_no_tx", 32'(q1.size()), 32'd0);
    check_val("tmo_busy", {31'd0, if1.busy_pro}, 32'd0);
    run_frame(1, 8'h0d, 64'h50, 64'h05, 1'b0);

    // A byte on the 19th idle clock is still in time
    err1 = 0;
    model(8'h0a, 64'h05, 64'h03, 1);
    q1.delete();
    send(1, 8'h0a);
    send(1, 8'h05);
    idle(19);
    send(1, 8'h03);
    wait_bytes(1, 2, 1'b0);
    compare_bytes(1, 8'h0a);
    check_val("tmo_edge_err", 32'(err1), 32'd0);
    idle(1);

    // Timeout disabled on dut2: long mid-frame stall then completion
    err2 = 0;
    model(8'h0b, 64'h0100, 64'h0001, 2);
    q2.delete();
    send(2, 8'h0b);
    send(2, 8'h01);
    idle(100);
    send(2, 8'h00);
    send(2, 8'h00);
    send(2, 8'h01);
    wait_bytes(2, 3, 1'b0);
    compare_bytes(2, 8'h0b);
    check_val("notmo_err", 32'(err2), 32'd0);
    idle(1);

    // rdy held high stalls output
    hold1 = 1;
    model(8'h0b, 64'h03, 64'h05, 1);
    q1.delete();
    send_frame(1, 8'h0b, 64'h03, 64'h05, 1'b0);
    idle(50);
    check_val("hold_no_tx", 32'(q1.size()), 32'd0);
    check_val("hold_busy", {31'd0, if1.busy_pro}, 32'd1);
    hold1 = 0;
    wait_bytes(1, 2, 1'b0);
    compare_bytes(1, 8'h0b);
    idle(1);

    // Reset while a send strobe is high
    hold1 = 1;
    q1.delete();
    send_frame(1, 8'h0a, 64'h05, 64'h03, 1'b0);
    idle(5);
    hold1 = 0;
    begin
      int budget = 200;
      while (!if1.en_dout_pro && budget > 0) begin idle(1); budget--; end
      check_val("midtx_strobe_seen", {31'd0, if1.en_dout_pro}, 32'd1);
    end
    res = 1'b0;
    #1;
    check_val("midtx_en", {31'd0, if1.en_dout_pro}, 32'd0);
    check_val("midtx_busy", {31'd0, if1.busy_pro}, 32'd0);
    idle(3);
    res = 1'b1;
    idle(30);
    check_val("midtx_no_more", 32'(q1.size()), 32'd0);

    // Random frames on both instances
    for (int n = 0; n < 60; n++) begin
      int d = (n % 2) + 1;
      int dw = 8 * d;
      longint unsigned mask = (64'd1 << dw) - 1;
      int sel = $urandom_range(0, 8);
      logic [7:0] op;
      longint unsigned a, b;
      op = (sel == 8) ? 8'(8'h20 + $urandom_range(0, 200)) : 8'(8'h0a + sel);
      a = longint'($urandom) & mask;
      b = longint'($urandom) & mask;
      if ((op == 8'h10 || op == 8'h11) && $urandom_range(0, 1) == 1)
        b = $urandom_range(0, dw + 3);
      if ($urandom_range(0, 7) == 0) b = a;
      run_frame(d, op, a, b, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cmd_alu_pro.md
Name: cmd_alu_pro

Overview:
Parametrised byte-stream command processor. It receives a frame of one opcode byte, then NB bytes of operand A, then NB bytes of operand B, all MSB first. It executes one of eight ALU operations and returns the NB-byte result followed by one status byte to the serial transmit block, handshaking on that block's rdy. Compared with the first-generation command processor it adds configurable operand width, XOR/CMP/shift opcodes, a flags/status byte, bad-opcode reporting and an inter-byte timeout.

Parameters:
NB, 1, operand/result width in bytes (1..4); DW = 8*NB bits
TIMEOUT, 1000, max idle clocks between bytes of one frame before abort; 0 disables the timeout
OP_ADD, 8'h0a, A+B
OP_SUB, 8'h0b, A-B
OP_AND, 8'h0c, A&B
OP_OR, 8'h0d, A|B
OP_XOR, 8'h0e, A^B
OP_CMP, 8'h0f, A-B computed for flags only; result bytes sent as 0
OP_SHL, 8'h10, A << B
OP_SHR, 8'h11, A >> B (logical)

Ports:
clk  input  1  system clock, rising edge
res  input  1  asynchronous active-low reset
din_pro  input  8  command/operand byte
en_din_pro  input  1  1-cycle strobe; din_pro valid
dout_pro  output  8  result/status byte to transmitter
en_dout_pro  output  1  1-cycle send strobe to transmitter
rdy  input  1  transmitter status; 0 = idle/ready
busy_pro  output  1  1 when not in IDLE; input strobes are dropped while high in EXEC/TX states
err_pro  output  1  1-cycle pulse on timeout abort

Behaviour:
- Reset (res=0, async): state=IDLE; dout_pro=0, en_dout_pro=0, busy_pro=0, err_pro=0; all operand, flag and counter registers cleared. Reset mid-frame or mid-TX abandons the frame; no further strobes are issued.
- States: IDLE, GET_A, GET_B, EXEC, TX_WAIT, TX_GAP.
- IDLE: en_din_pro -> latch opcode, go to GET_A with byte counter = 0.
- GET_A / GET_B: each strobe shifts din_pro into the LSB of the operand (operand <<= 8). After NB bytes, go to GET_B / EXEC respectively.
- Timeout: counter clears on every accepted byte and counts in GET_A/GET_B only. When it reaches TIMEOUT (TIMEOUT != 0): go to IDLE, pulse err_pro 1 cycle, send nothing. A strobe arriving in the same cycle the count reaches TIMEOUT is accepted and cancels the timeout.
- EXEC (1 cycle): compute result (DW bits) and status byte, load the TX buffer as NB result bytes plus the status byte, go to TX_WAIT.
- Arithmetic: ADD carry = bit DW of the (DW+1)-bit sum. SUB/CMP carry = borrow (A < B unsigned). Logic ops and shifts: carry = 0. Shift amount = B as unsigned; B >= DW gives result 0.
- Status byte: bit0 = carry/borrow; bit1 = zero (result == 0; for CMP, A == B); bit2 = bad opcode; bits7:3 = 0.
- Unknown opcode: result 0, status = 8'h04 (zero flag forced to 0). The frame is still fully consumed (2*NB operand bytes).
- TX_WAIT: when rdy == 0, drive dout_pro = next byte (MSB result byte first, status byte last), pulse en_dout_pro for exactly 1 cycle, go to TX_GAP.
- TX_GAP: 1 cycle in which rdy is ignored (the transmitter raises rdy within 1 cycle of the strobe). Then go to TX_WAIT, or to IDLE after the status byte.
- dout_pro holds its last value between strobes.
- en_din_pro in EXEC/TX_WAIT/TX_GAP is ignored; no queueing.
- Latency: the first en_dout_pro is asserted no earlier than 2 clocks after the edge that accepts the last B byte, provided rdy = 0.
- rdy held at 1 stalls output indefinitely. The timeout does not apply in TX states.

Test Plan:
- NB=1, rdy=0: strobes 0a,05,03 -> en_dout_pro pulses twice; bytes 08 then 00; busy_pro returns to 0.
- NB=1: 0b,03,05 -> FE, 01. Then 0f,7a,7a -> 00, 02. Then 10,81,01 -> 02, 00.
- NB=2: 0a,12,34,00,FF -> 13, 33, 00. Then 0a,FF,FF,00,01 -> 00, 00, 03.
- Bad opcode 55,11,22 -> 00, 04. Strobes sent during TX are ignored, and the next frame decodes correctly.
- TIMEOUT=20: send 0a,05, then idle 20 clocks -> one err_pro pulse, no en_dout_pro, state IDLE. A following complete frame works.
- Hold rdy=1 for 50 clocks after EXEC -> no strobe. Release rdy -> bytes follow with at least 2 clocks spacing. Assert res low mid-TX -> en_dout_pro=0 immediately, and no further bytes after res is released.
